// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
//
// Purpose:
//   Shares a single saturating add/sub datapath between two requesters.
//   A round-robin arbiter picks one requester at a time. The winner's operands
//   are captured, and the result is registered one cycle later. A done pulse
//   tags the result with the owning requester's ID.
//
//   Supported operations (opN):
//     00 : WIDTH-bit signed add, saturating to MAX/MIN
//     01 : WIDTH-bit signed subtract A-B, saturating to MAX/MIN
//     10 : WIDTH/4 independent signed 4-bit lane adds, each saturating
//     11 : bitwise XOR, never overflows
//
// Ports:
//   clk          system clock, rising edge active
//   rst_n        asynchronous active-low reset
//   req0/req1    level requests, held until the matching gnt is seen
//   A0/B0/op0    requester 0 operands and opcode
//   A1/B1/op1    requester 1 operands and opcode
//   gnt0/gnt1    one-cycle pulse: that requester's operands were captured
//   done         one-cycle pulse: Sum/Ovfl/done_id are valid
//   done_id      requester that owns the current result
//   Sum          result, holds until the next done
//   Ovfl         saturation flag, holds with Sum
//
// WIDTH must be a multiple of 4 so that the nibble mode has whole lanes.
// ---------------------------------------------------------------------------
module addsub_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl
);

  localparam int LANES = WIDTH / 4;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;

  // Operands latched from the winning requester at the arbitration edge.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             owner_q;

  // rr_ptr records the last requester served. rr_valid stays low until the
  // first grant after reset. While rr_valid is low, a tie goes to
  // requester 0 instead of to "not rr_ptr".
  logic             rr_ptr;
  logic             rr_valid;

  logic             pick_valid;
  logic             pick_id;

  logic [WIDTH-1:0] alu_sum;
  logic             alu_ovfl;
  logic [WIDTH:0]   arith;
  logic [4:0]       lane;

  // Full-width signed add or subtract with saturation.
  // The subtract is done as A + ~B + 1. The overflow rule is the usual one:
  // both addend signs match, and the raw result sign differs from them.
  // The saturation direction follows the sign of A.
  // Return value is {overflow, result}.
  function automatic logic [WIDTH:0] sat_addsub(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sub
  );
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] raw;
    logic             ovf;
    b_eff = sub ? ~b : b;
    raw   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    if (ovf)
      sat_addsub = {1'b1, (a[WIDTH-1] ? SAT_MIN : SAT_MAX)};
    else
      sat_addsub = {1'b0, raw};
  endfunction

  // One signed 4-bit lane add that saturates to 0x7 or 0x8.
  // Return value is {overflow, lane_result}.
  function automatic logic [4:0] lane_add(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [3:0] raw;
    raw = a + b;
    if ((a[3] == b[3]) && (raw[3] != a[3]))
      lane_add = {1'b1, (a[3] ? 4'h8 : 4'h7)};
    else
      lane_add = {1'b0, raw};
  endfunction

  // Arbitration decision. It is only acted on in IDLE or DONE.
  // With a single request there is no choice to make. On a tie, the
  // requester that was not served last wins, so neither side can starve.
  always_comb begin
    pick_valid = req0 | req1;
    if (req0 && req1)
      pick_id = rr_valid ? ~rr_ptr : 1'b0;
    else
      pick_id = req1;
  end

  // The datapath works on the latched operands during BUSY.
  // Its result is registered into Sum/Ovfl on the BUSY->DONE edge.
  // Nibble mode builds each lane on its own, so no carry crosses lanes.
  always_comb begin
    alu_sum  = '0;
    alu_ovfl = 1'b0;
    arith    = '0;
    lane     = '0;
    case (op_q)
      2'b00, 2'b01: begin
        arith    = sat_addsub(a_q, b_q, op_q[0]);
        alu_sum  = arith[WIDTH-1:0];
        alu_ovfl = arith[WIDTH];
      end
      2'b10: begin
        for (int i = 0; i < LANES; i++) begin
          lane             = lane_add(a_q[4*i +: 4], b_q[4*i +: 4]);
          alu_sum[4*i +: 4] = lane[3:0];
          alu_ovfl         = alu_ovfl | lane[4];
        end
      end
      default: begin
        alu_sum  = a_q ^ b_q;
        alu_ovfl = 1'b0;
      end
    endcase
  end

  // Control FSM. All outputs are registered here.
  // gnt and done are single-cycle pulses, so they default low every cycle.
  // Arbitration also runs in DONE, which sustains one op every two cycles.
  // Reset is asynchronous: an op in flight is dropped, and no gnt or done
  // follows for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      Sum      <= '0;
      Ovfl     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      owner_q  <= 1'b0;
      rr_ptr   <= 1'b0;
      rr_valid <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (pick_valid) begin
            state    <= BUSY;
            a_q      <= pick_id ? A1 : A0;
            b_q      <= pick_id ? B1 : B0;
            op_q     <= pick_id ? op1 : op0;
            owner_q  <= pick_id;
            gnt0     <= ~pick_id;
            gnt1     <= pick_id;
            rr_ptr   <= pick_id;
            rr_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          state   <= DONE;
          Sum     <= alu_sum;
          Ovfl    <= alu_ovfl;
          done_id <= owner_q;
          done    <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_arbiter
//
// Purpose:
//   Self-checking bench for addsub_arbiter.
//   Each issued op pushes its expected {requester, Sum, Ovfl} onto a queue.
//   The entry is popped and compared when done fires.
//   Expected values are either literal constants or come from a small
//   integer model that clamps true signed sums to the saturation range.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic [15:0] A0;
  logic [15:0] B0;
  logic [1:0]  op0;
  logic        req1;
  logic [15:0] A1;
  logic [15:0] B1;
  logic [1:0]  op1;
  logic        gnt0;
  logic        gnt1;
  logic        done;
  logic        done_id;
  logic [15:0] Sum;
  logic        Ovfl;

  typedef struct packed {
    logic        id;
    logic [15:0] sum;
    logic        ovfl;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic last_gnt    = 1'b0;

  addsub_arbiter #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .A0      (A0),
    .B0      (B0),
    .op0     (op0),
    .req1    (req1),
    .A1      (A1),
    .B1      (B1),
    .op1     (op1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .done    (done),
    .done_id (done_id),
    .Sum     (Sum),
    .Ovfl    (Ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs past every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: true signed result from integer math, then clamped.
  // Returns {ovfl, sum}.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int          s;
    int          ls;
    logic [15:0] r;
    logic        o;
    r = '0;
    o = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        if (op == 2'b00) s = int'($signed(a)) + int'($signed(b));
        else             s = int'($signed(a)) - int'($signed(b));
        if (s > 32767)       begin r = 16'h7FFF; o = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; o = 1'b1; end
        else                 r = s[15:0];
      end
      2'b10: begin
        for (int i = 0; i < 4; i++) begin
          ls = int'($signed(a[4*i +: 4])) + int'($signed(b[4*i +: 4]));
          if (ls > 7)       begin r[4*i +: 4] = 4'h7; o = 1'b1; end
          else if (ls < -8) begin r[4*i +: 4] = 4'h8; o = 1'b1; end
          else              r[4*i +: 4] = ls[3:0];
        end
      end
      default: r = a ^ b;
    endcase
    return {o, r};
  endfunction

  // Invariants checked on every cycle outside reset:
  // the two grants never overlap, and every done directly follows a grant.
  always @(negedge clk) begin
    if (rst_n) begin
      check_output("gnt_overlap", {31'd0, gnt0 & gnt1}, 32'd0);
      if (done === 1'b1)
        check_output("done_after_gnt", {31'd0, last_gnt}, 32'd1);
      last_gnt = gnt0 | gnt1;
    end else begin
      last_gnt = 1'b0;
    end
  end

  // Drives one requester's request and operands. Call this at a negedge.
  task automatic apply_stimulus(input logic id, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    if (id) begin req1 = 1'b1; A1 = a; B1 = b; op1 = op; end
    else    begin req0 = 1'b1; A0 = a; B0 = b; op0 = op; end
  endtask

  // Waits a bounded number of cycles for done, then pops and compares.
  // Expects to be called at the negedge where done should already be high.
  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_done"}, {31'd0, done}, 32'd1);
    check_output({tag, "_latency"}, n, 32'd0);
    if (sb.size() == 0) begin
      check_output({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (done === 1'b1) begin
        check_output({tag, "_id"}, {31'd0, done_id}, {31'd0, e.id});
        check_output({tag, "_sum"}, {16'd0, Sum}, {16'd0, e.sum});
        check_output({tag, "_ovfl"}, {31'd0, Ovfl}, {31'd0, e.ovfl});
      end
    end
  endtask

  // Runs one complete, isolated op: request, grant, done, then Sum hold.
  task automatic do_op(input string tag, input logic id, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [15:0] exp_sum, input logic exp_ovfl);
    apply_stimulus(id, a, b, op);
    sb.push_back('{id: id, sum: exp_sum, ovfl: exp_ovfl});
    @(negedge clk);
    check_output({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, ~id});
    check_output({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, id});
    if (id) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    wait_done(tag);
    @(negedge clk);
    check_output({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_output({tag, "_sum_hold"}, {16'd0, Sum}, {16'd0, exp_sum});
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [1:0]  rop;
    logic [16:0] m;

    rst_n = 1'b0;
    req0 = 1'b0; A0 = '0; B0 = '0; op0 = 2'b00;
    req1 = 1'b0; A1 = '0; B1 = '0; op1 = 2'b00;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_output("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check_output("rst_gnt1", {31'd0, gnt1}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_done_id", {31'd0, done_id}, 32'd0);
    check_output("rst_sum", {16'd0, Sum}, 32'd0);
    check_output("rst_ovfl", {31'd0, Ovfl}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    do_op("add_pos_ovf",  1'b0, 16'h7FFF, 16'h0001, 2'b00, 16'h7FFF, 1'b1);
    do_op("add_neg_ovf",  1'b1, 16'h8800, 16'h8901, 2'b00, 16'h8000, 1'b1);
    do_op("sub_plain",    1'b1, 16'h1111, 16'h0111, 2'b01, 16'h1000, 1'b0);
    do_op("sub_neg_ovf",  1'b0, 16'h8000, 16'h0001, 2'b01, 16'h8000, 1'b1);
    do_op("sub_pos_ovf",  1'b1, 16'h7FFF, 16'hFFFF, 2'b01, 16'h7FFF, 1'b1);
    do_op("nib_neg",      1'b0, 16'h8009, 16'h9009, 2'b10, 16'h8008, 1'b1);
    do_op("nib_mixed",    1'b1, 16'h0FD8, 16'h0019, 2'b10, 16'h0FE8, 1'b1);
    do_op("nib_plain",    1'b0, 16'h1111, 16'h1111, 2'b10, 16'h2222, 1'b0);
    do_op("xor",          1'b0, 16'hA5A5, 16'h0FF0, 2'b11, 16'hAA55, 1'b0);

    // Round-robin: both requests held from reset.
    // Each requester drops after its grant and re-requests in its DONE cycle.
    rst_n = 1'b0;
    ra = 16'($urandom); rb = 16'($urandom); rop = 2'($urandom_range(0, 3));
    apply_stimulus(1'b0, ra, rb, rop);
    m = model(ra, rb, rop);
    sb.push_back('{id: 1'b0, sum: m[15:0], ovfl: m[16]});
    ra = 16'($urandom); rb = 16'($urandom); rop = 2'($urandom_range(0, 3));
    apply_stimulus(1'b1, ra, rb, rop);
    m = model(ra, rb, rop);
    sb.push_back('{id: 1'b1, sum: m[15:0], ovfl: m[16]});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic w;
      w = k[0];
      @(negedge clk);
      check_output("rr_gnt0", {31'd0, gnt0}, {31'd0, ~w});
      check_output("rr_gnt1", {31'd0, gnt1}, {31'd0, w});
      check_output("rr_no_done_in_busy", {31'd0, done}, 32'd0);
      if (w) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clk);
      wait_done("rr");
      check_output("rr_no_gnt_in_done", {31'd0, gnt0 | gnt1}, 32'd0);
      if (k < 2) begin
        ra = 16'($urandom); rb = 16'($urandom); rop = 2'($urandom_range(0, 3));
        apply_stimulus(w, ra, rb, rop);
        m = model(ra, rb, rop);
        sb.push_back('{id: w, sum: m[15:0], ovfl: m[16]});
      end
    end
    @(negedge clk);

    // Reset mid-op: assert reset asynchronously during BUSY.
    // The op is not pushed to the scoreboard because it must never complete.
    apply_stimulus(1'b1, 16'h1234, 16'h1111, 2'b00);
    @(negedge clk);
    check_output("mid_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_gnt1", {31'd0, gnt1}, 32'd0);
    check_output("mid_rst_done", {31'd0, done}, 32'd0);
    check_output("mid_rst_sum", {16'd0, Sum}, 32'd0);
    check_output("mid_rst_ovfl", {31'd0, Ovfl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("post_rst_no_done", {31'd0, done}, 32'd0);
    end

    // After reset, a tie goes to requester 0 first, then to requester 1.
    apply_stimulus(1'b1, 16'h0003, 16'h0004, 2'b00);
    sb.push_back('{id: 1'b0, sum: 16'h0000, ovfl: 1'b0});
    sb.push_back('{id: 1'b1, sum: 16'h0007, ovfl: 1'b0});
    apply_stimulus(1'b0, 16'h5555, 16'h5555, 2'b11);
    @(negedge clk);
    check_output("tie_gnt0", {31'd0, gnt0}, 32'd1);
    check_output("tie_gnt1", {31'd0, gnt1}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    wait_done("tie_first");
    @(negedge clk);
    check_output("tie_second_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    wait_done("tie_second");
    @(negedge clk);
    check_output("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
